// File: rtl/pipe_pkg.sv
// Shared pipeline constants: exception codes and the stage names used across the core.
package pipe_pkg;

  localparam int unsigned EXC_W = 7;

  localparam logic [EXC_W-1:0] EXC_NONE      = 7'd0;
  localparam logic [EXC_W-1:0] EXC_DECODE    = 7'd1;
  localparam logic [EXC_W-1:0] EXC_ALU_OVF   = 7'd2;
  localparam logic [EXC_W-1:0] EXC_MEM_ALIGN = 7'd3;
  localparam logic [EXC_W-1:0] EXC_ILLEGAL   = 7'd4;
  localparam logic [EXC_W-1:0] EXC_SYSCALL   = 7'd5;

  localparam int unsigned STG_DEC = 0;
  localparam int unsigned STG_ALU = 2;
  localparam int unsigned STG_MEM = 3;
  localparam int unsigned STG_WB  = 4;

endpackage

// File: rtl/pipe_slot.sv
// One pipeline stage slot: a valid bit and the PC of the instruction it holds.
module pipe_slot #(
  parameter int unsigned PC_W = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            load,
  input  logic            clear,
  input  logic [PC_W-1:0] pc_in,
  output logic            valid,
  output logic [PC_W-1:0] pc
);

  // clear beats load so a flush or exception can kill an incoming instruction
  always_ff @(posedge clk) begin
    if (rst) begin
      valid <= 1'b0;
      pc    <= '0;
    end else if (clear) begin
      valid <= 1'b0;
    end else if (load) begin
      valid <= 1'b1;
      pc    <= pc_in;
    end
  end

endmodule

// File: rtl/pipeline_ctrl.sv
// Per-stage valid/advance control with back-pressure, late-branch flush,
// precise halt on a retiring exception and a stretched datapath reset.
module pipeline_ctrl #(
  parameter int unsigned STAGES      = 5,
  parameter int unsigned BR_STAGE    = pipe_pkg::STG_ALU,
  parameter int unsigned RST_STRETCH = 2,
  parameter int unsigned PC_W        = 32,
  parameter int unsigned EXC_W       = pipe_pkg::EXC_W
) (
  input  logic                   clk,
  input  logic                   rst,
  output logic                   rst_out,
  input  logic                   fetch_valid,
  input  logic [PC_W-1:0]        fetch_pc,
  output logic                   fetch_ready,
  input  logic [STAGES-1:0]      stall_req,
  input  logic                   flush_req,
  input  logic [EXC_W-1:0]       retire_exc,
  output logic [STAGES-1:0]      stage_valid,
  output logic [STAGES-1:0]      stage_advance,
  output logic [STAGES*PC_W-1:0] stage_pc,
  output logic                   halted,
  output logic [EXC_W-1:0]       exc_code,
  output logic [PC_W-1:0]        exc_pc,
  output logic [31:0]            retire_count
);

  import pipe_pkg::*;

  localparam int unsigned LAST = STAGES - 1;
  localparam logic [STAGES-1:0] YOUNG_MASK = STAGES'((64'd1 << BR_STAGE) - 64'd1);

  logic [3:0]             stretch_cnt;
  logic                   rst_int;
  logic [STAGES-1:0]      valid;
  logic [STAGES*PC_W-1:0] pc_flat;
  logic [STAGES-1:0]      move;
  logic [STAGES-1:0]      ready;
  logic [STAGES-1:0]      mv;
  logic [STAGES-1:0]      load;
  logic [STAGES-1:0]      clear;
  logic                   flush;
  logic                   take;
  logic                   ready_in;
  logic                   exc_fire;
  logic                   retire_ok;
  logic                   halted_q;
  logic [EXC_W-1:0]       exc_code_q;
  logic [PC_W-1:0]        exc_pc_q;
  logic [31:0]            retire_q;

  always_ff @(posedge clk) begin
    if (rst)
      stretch_cnt <= 4'(RST_STRETCH);
    else if (stretch_cnt != '0)
      stretch_cnt <= stretch_cnt - 4'd1;
  end

  assign rst_int = rst | (stretch_cnt != '0);

  // Ready ripples from retire back towards decode through a scalar carry.
  always_comb begin : ready_chain
    logic r;
    move = '0;
    ready = '0;
    r = 1'b1;
    for (int unsigned k = 0; k < STAGES; k++) begin
      move[LAST-k]  = valid[LAST-k] & ~stall_req[LAST-k] & r;
      ready[LAST-k] = ~valid[LAST-k] | move[LAST-k];
      r = ready[LAST-k];
    end
  end

  assign flush     = flush_req & valid[BR_STAGE];
  assign ready_in  = ready[0] & ~halted_q & ~rst_int & ~flush;
  assign take      = fetch_valid & ready_in;
  assign exc_fire  = move[LAST] & (retire_exc != EXC_W'(EXC_NONE)) & ~halted_q;
  assign retire_ok = move[LAST] & (retire_exc == EXC_W'(EXC_NONE)) & ~halted_q;

  // Flushed younger stages do not hand their content on; BR_STAGE then bubbles.
  assign mv    = move & ~({STAGES{flush}} & YOUNG_MASK);
  assign load  = {mv[STAGES-2:0], take};
  assign clear = {STAGES{exc_fire}} | ({STAGES{flush}} & YOUNG_MASK) | (mv & ~load);

  for (genvar g = 0; g < STAGES; g++) begin : g_slot
    logic [PC_W-1:0] src;
    if (g == 0) begin : g_head
      assign src = fetch_pc;
    end else begin : g_body
      assign src = pc_flat[(g-1)*PC_W +: PC_W];
    end
    pipe_slot #(.PC_W(PC_W)) u_slot (
      .clk   (clk),
      .rst   (rst_int),
      .load  (load[g]),
      .clear (clear[g]),
      .pc_in (src),
      .valid (valid[g]),
      .pc    (pc_flat[g*PC_W +: PC_W])
    );
  end

  always_ff @(posedge clk) begin
    if (rst_int) begin
      halted_q   <= 1'b0;
      exc_code_q <= '0;
      exc_pc_q   <= '0;
      retire_q   <= '0;
    end else begin
      if (exc_fire) begin
        halted_q   <= 1'b1;
        exc_code_q <= retire_exc;
        exc_pc_q   <= pc_flat[LAST*PC_W +: PC_W];
      end
      if (retire_ok)
        retire_q <= retire_q + 32'd1;
    end
  end

  // Outputs are forced low for the whole stretched reset, including its first cycle.
  assign rst_out       = rst_int;
  assign fetch_ready   = ready_in;
  assign stage_valid   = rst_int ? '0 : valid;
  assign stage_advance = rst_int ? '0 : load;
  assign stage_pc      = rst_int ? '0 : pc_flat;
  assign halted        = rst_int ? 1'b0 : halted_q;
  assign exc_code      = rst_int ? '0 : exc_code_q;
  assign exc_pc        = rst_int ? '0 : exc_pc_q;
  assign retire_count  = rst_int ? '0 : retire_q;

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Directed bench for pipeline_ctrl with default parameters (5 stages, branch at 2, stretch 2).
module tb_pipeline_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        rst_out;
  logic        fetch_valid;
  logic [31:0] fetch_pc;
  logic        fetch_ready;
  logic [4:0]  stall_req;
  logic        flush_req;
  logic [6:0]  retire_exc;
  logic [4:0]  stage_valid;
  logic [4:0]  stage_advance;
  logic [159:0] stage_pc;
  logic        halted;
  logic [6:0]  exc_code;
  logic [31:0] exc_pc;
  logic [31:0] retire_count;

  int nchk = 0;
  int nerr = 0;

  always #5 clk = ~clk;

  pipeline_ctrl #(.STAGES(5), .BR_STAGE(2), .RST_STRETCH(2), .PC_W(32), .EXC_W(7)) dut (
    .clk(clk), .rst(rst), .rst_out(rst_out),
    .fetch_valid(fetch_valid), .fetch_pc(fetch_pc), .fetch_ready(fetch_ready),
    .stall_req(stall_req), .flush_req(flush_req), .retire_exc(retire_exc),
    .stage_valid(stage_valid), .stage_advance(stage_advance), .stage_pc(stage_pc),
    .halted(halted), .exc_code(exc_code), .exc_pc(exc_pc), .retire_count(retire_count)
  );

  typedef struct {
    logic        rst;
    logic        fv;
    logic [31:0] fpc;
    logic [4:0]  stall;
    logic        flush;
    logic [6:0]  exc;
    logic        ero;
    logic        erdy;
    logic [4:0]  ev;
    logic [4:0]  ea;
    logic [31:0] pc [5];
    logic [31:0] ret;
  } vec_t;

  vec_t vq[$];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic r, input logic fv, input logic [31:0] p,
                       input logic [4:0] st, input logic fl, input logic [6:0] ex);
    rst = r; fetch_valid = fv; fetch_pc = p; stall_req = st; flush_req = fl; retire_exc = ex;
  endtask

  function automatic logic [31:0] spc(input int i);
    return stage_pc[i*32 +: 32];
  endfunction

  function automatic vec_t mk(input logic r, input logic fv, input logic [31:0] fpc,
                              input logic [4:0] st, input logic fl, input logic [6:0] ex,
                              input logic ero, input logic erdy, input logic [4:0] ev,
                              input logic [4:0] ea, input logic [31:0] p0, input logic [31:0] p1,
                              input logic [31:0] p2, input logic [31:0] p3, input logic [31:0] p4,
                              input logic [31:0] ret);
    vec_t v;
    v.rst = r; v.fv = fv; v.fpc = fpc; v.stall = st; v.flush = fl; v.exc = ex;
    v.ero = ero; v.erdy = erdy; v.ev = ev; v.ea = ea;
    v.pc[0] = p0; v.pc[1] = p1; v.pc[2] = p2; v.pc[3] = p3; v.pc[4] = p4;
    v.ret = ret;
    return v;
  endfunction

  task automatic reset_seq();
    drive(1'b1, 1'b1, 32'h0, '0, 1'b0, '0);
    #2 chk("rst cycle rst_out", 64'(rst_out), 64'd1);
    chk("rst cycle valid", 64'(stage_valid), 64'd0);
    tick();
    drive(1'b0, 1'b1, 32'h0, '0, 1'b0, '0);
    #2 chk("stretch1 rst_out", 64'(rst_out), 64'd1);
    chk("stretch1 fetch_ready", 64'(fetch_ready), 64'd0);
    tick();
    #2 chk("stretch2 rst_out", 64'(rst_out), 64'd1);
    tick();
    #1 chk("post-stretch rst_out", 64'(rst_out), 64'd0);
  endtask

  initial begin
    vec_t r;
    drive(1'b1, 1'b1, 32'h0, '0, 1'b0, '0);

    // reset: rst one cycle, rst_out three cycles, offers refused throughout
    vq.push_back(mk(1, 1, 32'h0, 0, 0, 0, 1, 0, 5'h00, 5'h00, 0, 0, 0, 0, 0, 0));
    vq.push_back(mk(0, 1, 32'h0, 0, 0, 0, 1, 0, 5'h00, 5'h00, 0, 0, 0, 0, 0, 0));
    vq.push_back(mk(0, 1, 32'h0, 0, 0, 0, 1, 0, 5'h00, 5'h00, 0, 0, 0, 0, 0, 0));
    // unstalled stream: stage i holds PC 4*(c-1-i) at cycle c
    for (int c = 0; c < 16; c++) begin
      logic [4:0] vm, am;
      vm = (c >= 5) ? 5'h1f : 5'((1 << c) - 1);
      am = (c >= 4) ? 5'h1f : 5'((1 << (c + 1)) - 1);
      r = mk(0, 1, 32'(4 * c), 0, 0, 0, 0, 1, vm, am, 0, 0, 0, 0, 0,
             (c > 5) ? 32'(c - 5) : 32'd0);
      for (int i = 0; i < 5; i++) r.pc[i] = 32'(4 * (c - 1 - i));
      vq.push_back(r);
    end
    // stall stage 1 for two cycles on a full pipe
    vq.push_back(mk(0, 1, 32'h40, 5'h02, 0, 0, 0, 0, 5'h1f, 5'h18, 32'h3c, 32'h38, 32'h34, 32'h30, 32'h2c, 11));
    vq.push_back(mk(0, 1, 32'h40, 5'h02, 0, 0, 0, 0, 5'h1b, 5'h10, 32'h3c, 32'h38, 0, 32'h34, 32'h30, 12));
    vq.push_back(mk(0, 1, 32'h40, 5'h00, 0, 0, 0, 1, 5'h13, 5'h07, 32'h3c, 32'h38, 0, 0, 32'h34, 13));
    vq.push_back(mk(0, 1, 32'h44, 5'h00, 0, 0, 0, 1, 5'h07, 5'h0f, 32'h40, 32'h3c, 32'h38, 0, 0, 14));
    vq.push_back(mk(0, 1, 32'h48, 5'h00, 0, 0, 0, 1, 5'h0f, 5'h1f, 32'h44, 32'h40, 32'h3c, 32'h38, 0, 14));
    // reset with a populated pipe
    vq.push_back(mk(1, 1, 32'h4c, 0, 0, 0, 1, 0, 5'h00, 5'h00, 0, 0, 0, 0, 0, 0));
    vq.push_back(mk(0, 0, 32'h0, 0, 0, 0, 1, 0, 5'h00, 5'h00, 0, 0, 0, 0, 0, 0));
    vq.push_back(mk(0, 0, 32'h0, 0, 0, 0, 1, 0, 5'h00, 5'h00, 0, 0, 0, 0, 0, 0));
    // flush; the first flush_req lands on an empty branch stage and is ignored
    vq.push_back(mk(0, 1, 32'h08, 0, 0, 0, 0, 1, 5'h00, 5'h01, 0, 0, 0, 0, 0, 0));
    vq.push_back(mk(0, 1, 32'h0c, 0, 1, 0, 0, 1, 5'h01, 5'h03, 32'h08, 0, 0, 0, 0, 0));
    vq.push_back(mk(0, 1, 32'h10, 0, 0, 0, 0, 1, 5'h03, 5'h07, 32'h0c, 32'h08, 0, 0, 0, 0));
    vq.push_back(mk(0, 1, 32'h14, 0, 0, 0, 0, 1, 5'h07, 5'h0f, 32'h10, 32'h0c, 32'h08, 0, 0, 0));
    vq.push_back(mk(0, 1, 32'h18, 0, 0, 0, 0, 1, 5'h0f, 5'h1f, 32'h14, 32'h10, 32'h0c, 32'h08, 0, 0));
    vq.push_back(mk(0, 1, 32'h1c, 0, 1, 0, 0, 0, 5'h1f, 5'h18, 32'h18, 32'h14, 32'h10, 32'h0c, 32'h08, 0));
    vq.push_back(mk(0, 1, 32'h40, 0, 0, 0, 0, 1, 5'h18, 5'h11, 0, 0, 0, 32'h10, 32'h0c, 1));
    vq.push_back(mk(0, 0, 32'h0, 0, 0, 0, 0, 1, 5'h11, 5'h02, 32'h40, 0, 0, 0, 32'h10, 2));

    foreach (vq[n]) begin
      drive(vq[n].rst, vq[n].fv, vq[n].fpc, vq[n].stall, vq[n].flush, vq[n].exc);
      #2;
      chk($sformatf("row%0d rst_out", n), 64'(rst_out), 64'(vq[n].ero));
      chk($sformatf("row%0d fetch_ready", n), 64'(fetch_ready), 64'(vq[n].erdy));
      chk($sformatf("row%0d stage_valid", n), 64'(stage_valid), 64'(vq[n].ev));
      chk($sformatf("row%0d stage_advance", n), 64'(stage_advance), 64'(vq[n].ea));
      chk($sformatf("row%0d retire_count", n), 64'(retire_count), 64'(vq[n].ret));
      chk($sformatf("row%0d halted", n), 64'(halted), 64'd0);
      for (int i = 0; i < 5; i++)
        if (vq[n].ev[i] || vq[n].ero)
          chk($sformatf("row%0d stage_pc[%0d]", n, i), 64'(spc(i)), 64'(vq[n].pc[i]));
      tick();
    end

    // exception at a stalled retire stage waits; then halts precisely
    reset_seq();
    for (int e = 0; e < 9; e++) begin
      drive(1'b0, 1'b1, 32'(32'h14 + 4 * e), '0, 1'b0, '0);
      #2 chk($sformatf("exc fill%0d fetch_ready", e), 64'(fetch_ready), 64'd1);
      tick();
    end
    drive(1'b0, 1'b1, 32'h38, 5'h10, 1'b0, 7'h05);
    #2 chk("exc stalled pc4", 64'(spc(4)), 64'h24);
    chk("exc stalled advance", 64'(stage_advance), 64'h00);
    chk("exc stalled retire", 64'(retire_count), 64'd4);
    tick();
    drive(1'b0, 1'b1, 32'h38, 5'h00, 1'b0, 7'h05);
    #2 chk("exc fire halted", 64'(halted), 64'd0);
    chk("exc fire advance", 64'(stage_advance), 64'h1f);
    tick();
    drive(1'b0, 1'b1, 32'h3c, 5'h00, 1'b0, 7'h00);
    #2 chk("exc halted", 64'(halted), 64'd1);
    chk("exc code", 64'(exc_code), 64'h05);
    chk("exc pc", 64'(exc_pc), 64'h24);
    chk("exc valid", 64'(stage_valid), 64'h00);
    chk("exc fetch_ready", 64'(fetch_ready), 64'd0);
    chk("exc retire", 64'(retire_count), 64'd4);
    tick();
    drive(1'b0, 1'b1, 32'h40, 5'h00, 1'b1, 7'h03);
    tick();
    drive(1'b0, 1'b0, 32'h0, 5'h00, 1'b0, 7'h00);
    #2 chk("exc sticky code", 64'(exc_code), 64'h05);
    chk("exc sticky pc", 64'(exc_pc), 64'h24);
    chk("exc sticky retire", 64'(retire_count), 64'd4);
    tick();

    // flush and exception together, then reset and resume
    reset_seq();
    for (int f = 0; f < 5; f++) begin
      drive(1'b0, 1'b1, 32'(32'h100 + 4 * f), '0, 1'b0, '0);
      tick();
    end
    drive(1'b0, 1'b1, 32'h114, 5'h00, 1'b1, 7'h02);
    #2 chk("both fetch_ready", 64'(fetch_ready), 64'd0);
    chk("both pc4", 64'(spc(4)), 64'h100);
    chk("both pc2", 64'(spc(2)), 64'h108);
    chk("both advance", 64'(stage_advance), 64'h18);
    tick();
    drive(1'b0, 1'b1, 32'h118, 5'h00, 1'b0, 7'h00);
    #2 chk("both halted", 64'(halted), 64'd1);
    chk("both code", 64'(exc_code), 64'h02);
    chk("both exc_pc", 64'(exc_pc), 64'h100);
    chk("both valid", 64'(stage_valid), 64'h00);
    tick();
    drive(1'b1, 1'b1, 32'h118, 5'h00, 1'b0, 7'h00);
    #2 chk("rst halted", 64'(halted), 64'd0);
    chk("rst code", 64'(exc_code), 64'd0);
    chk("rst exc_pc", 64'(exc_pc), 64'd0);
    chk("rst retire", 64'(retire_count), 64'd0);
    chk("rst stage_pc", 64'(stage_pc[63:0]), 64'd0);
    tick();
    drive(1'b0, 1'b1, 32'h200, 5'h00, 1'b0, 7'h00);
    #2 chk("resume stretch", 64'(rst_out), 64'd1);
    tick();
    tick();
    for (int k = 0; k < 7; k++) begin
      drive(1'b0, 1'b1, 32'(32'h200 + 4 * k), '0, 1'b0, '0);
      #2;
      if (k == 5) begin
        chk("resume valid", 64'(stage_valid), 64'h1f);
        chk("resume pc4", 64'(spc(4)), 64'h200);
      end
      if (k == 6) begin
        chk("resume retire", 64'(retire_count), 64'd1);
        chk("resume halted", 64'(halted), 64'd0);
      end
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
    $finish;
  end

endmodule
